// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcode and FSM state types shared by the RPN calculator
package calc_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH  = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_EQ    = 4'd6,
        OP_LTU   = 4'd7,
        OP_DUP   = 4'd8,
        OP_SWAP  = 4'd9,
        OP_DROP  = 4'd10,
        OP_CLEAR = 4'd11,
        OP_ADDI  = 4'd12
    } op_e;

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_e;

endpackage

// File: rtl/rpn_calculator_if.sv
// rtl/rpn_calculator_if.sv - switch/display signal bundle of the RPN calculator
interface rpn_calculator_if
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]             NumIn;
    logic [OP_W-1:0]              OpIn;
    logic                         Enter;
    logic [WIDTH-1:0]             NumOut;
    logic [$clog2(DEPTH+1)-1:0]   Depth;
    logic                         Carry;
    logic                         Error;

    modport master (output NumIn, OpIn, Enter, input NumOut, Depth, Carry, Error);
    modport slave  (input NumIn, OpIn, Enter, output NumOut, Depth, Carry, Error);
endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational two-operand ALU computing f(b,a)
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             writes_carry
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of the difference goes high exactly when b < a.
    assign sum  = {1'b0, b} + {1'b0, a};
    assign diff = {1'b0, b} - {1'b0, a};

    always_comb begin
        result       = a;
        carry        = 1'b0;
        writes_carry = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                result       = sum[WIDTH-1:0];
                carry        = sum[WIDTH];
                writes_carry = 1'b1;
            end
            OP_SUB: begin
                result       = diff[WIDTH-1:0];
                carry        = diff[WIDTH];
                writes_carry = 1'b1;
            end
            OP_AND: result = b & a;
            OP_OR:  result = b | a;
            OP_XOR: result = b ^ a;
            OP_EQ: begin
                result    = '0;
                result[0] = (b == a);
            end
            OP_LTU: begin
                result    = '0;
                result[0] = (b < a);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/rpn_calculator.sv
// rtl/rpn_calculator.sv - stack-based RPN calculator, one operation per Enter press
module rpn_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             Reset,
    rpn_calculator_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    state_e           state_q, state_d;

    op_e              op;
    logic             exec;
    logic [WIDTH-1:0] a_val, b_val, alu_b, alu_res;
    logic             alu_carry, alu_wc;
    int               dep;

    assign op  = op_e'(bus.OpIn);
    assign dep = int'(depth_q);

    // Entry 0 is the bottom; a and b read 0 when they do not exist.
    always_comb begin
        a_val = '0;
        b_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dep == i + 1) a_val = stack_q[i];
            if (dep == i + 2) b_val = stack_q[i];
        end
    end

    assign alu_b = (op == OP_ADDI) ? bus.NumIn : b_val;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a            (a_val),
        .b            (alu_b),
        .op           (op),
        .result       (alu_res),
        .carry        (alu_carry),
        .writes_carry (alu_wc)
    );

    always_comb begin
        state_d = state_q;
        exec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Enter) begin
                    exec    = 1'b1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: if (!bus.Enter) state_d = IDLE;
            default:      state_d = WAIT_RELEASE;
        endcase
    end

    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        carry_d = carry_q;
        err_d   = err_q;
        if (exec) begin
            case (op)
                OP_PUSH, OP_DUP: begin
                    if (dep == DEPTH || (op == OP_DUP && dep == 0)) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == dep) stack_d[i] = (op == OP_PUSH) ? bus.NumIn : a_val;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_EQ, OP_LTU: begin
                    if (dep < 2) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == dep - 2) stack_d[i] = alu_res;
                        depth_d = depth_q - DW'(1);
                        if (alu_wc) carry_d = alu_carry;
                    end
                end
                OP_SWAP: begin
                    if (dep < 2) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i == dep - 1) stack_d[i] = b_val;
                            if (i == dep - 2) stack_d[i] = a_val;
                        end
                    end
                end
                OP_DROP: begin
                    if (dep == 0) err_d = 1'b1;
                    else          depth_d = depth_q - DW'(1);
                end
                OP_ADDI: begin
                    if (dep == 0) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++)
                            if (i == dep - 1) stack_d[i] = alu_res;
                        carry_d = alu_carry;
                    end
                end
                OP_CLEAR: begin
                    depth_d = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Reset parks the FSM in WAIT_RELEASE so a held Enter cannot fire on exit.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= WAIT_RELEASE;
            depth_q <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign bus.NumOut = a_val;
    assign bus.Depth  = depth_q;
    assign bus.Carry  = carry_q;
    assign bus.Error  = err_q;
endmodule

// File: tb/tb_rpn_calculator.sv
// tb/tb_rpn_calculator.sv - directed scoreboard bench for rpn_calculator
module tb_rpn_calculator;
    import calc_pkg::*;

    typedef struct {
        string      tag;
        logic [7:0] num;
        logic [2:0] dep;
        logic       carry;
        logic       err;
    } exp_t;

    logic clock = 1'b0;
    logic Reset = 1'b1;
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    rpn_calculator_if #(.WIDTH(8), .DEPTH(4)) bus ();

    rpn_calculator #(.WIDTH(8), .DEPTH(4)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [7:0] num, input logic [2:0] dep,
                                input logic carry, input logic err);
        exp_t e;
        e.tag = tag; e.num = num; e.dep = dep; e.carry = carry; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_state();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".NumOut"}, 32'(bus.NumOut), 32'(e.num));
            chk({e.tag, ".Depth"},  32'(bus.Depth),  32'(e.dep));
            chk({e.tag, ".Carry"},  32'(bus.Carry),  32'(e.carry));
            chk({e.tag, ".Error"},  32'(bus.Error),  32'(e.err));
        end
    endtask

    task automatic press(input string tag, input op_e op, input logic [7:0] num,
                         input logic [7:0] en, input logic [2:0] ed, input logic ec, input logic ee);
        bus.Enter = 1'b0;
        @(negedge clock);
        bus.OpIn  = op;
        bus.NumIn = num;
        bus.Enter = 1'b1;
        expect_state(tag, en, ed, ec, ee);
        @(negedge clock);
        check_state();
        bus.Enter = 1'b0;
    endtask

    initial begin
        logic [3:0] rsv;
        bus.NumIn = '0;
        bus.OpIn  = '0;
        bus.Enter = 1'b0;
        repeat (3) @(negedge clock);
        expect_state("reset", 8'd0, 3'd0, 1'b0, 1'b0);
        check_state();
        Reset = 1'b0;

        press("push200", OP_PUSH, 8'd200, 8'd200, 3'd1, 1'b0, 1'b0);
        press("push100", OP_PUSH, 8'd100, 8'd100, 3'd2, 1'b0, 1'b0);
        press("add_wrap", OP_ADD, 8'd0, 8'd44, 3'd1, 1'b1, 1'b0);
        press("clear1", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        press("push5", OP_PUSH, 8'd5, 8'd5, 3'd1, 1'b0, 1'b0);
        press("push7", OP_PUSH, 8'd7, 8'd7, 3'd2, 1'b0, 1'b0);
        press("sub_borrow", OP_SUB, 8'd0, 8'd254, 3'd1, 1'b1, 1'b0);
        press("push254", OP_PUSH, 8'd254, 8'd254, 3'd2, 1'b1, 1'b0);
        press("eq", OP_EQ, 8'd0, 8'd1, 3'd1, 1'b1, 1'b0);
        press("push3", OP_PUSH, 8'd3, 8'd3, 3'd2, 1'b1, 1'b0);
        press("and", OP_AND, 8'd0, 8'd1, 3'd1, 1'b1, 1'b0);
        press("clear2", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        press("push12", OP_PUSH, 8'd12, 8'd12, 3'd1, 1'b0, 1'b0);
        press("dup", OP_DUP, 8'd0, 8'd12, 3'd2, 1'b0, 1'b0);
        press("push10", OP_PUSH, 8'd10, 8'd10, 3'd3, 1'b0, 1'b0);
        press("xor", OP_XOR, 8'd0, 8'd6, 3'd2, 1'b0, 1'b0);
        press("or", OP_OR, 8'd0, 8'd14, 3'd1, 1'b0, 1'b0);
        press("push20", OP_PUSH, 8'd20, 8'd20, 3'd2, 1'b0, 1'b0);
        press("ltu", OP_LTU, 8'd0, 8'd1, 3'd1, 1'b0, 1'b0);
        press("push3b", OP_PUSH, 8'd3, 8'd3, 3'd2, 1'b0, 1'b0);
        press("swap", OP_SWAP, 8'd0, 8'd1, 3'd2, 1'b0, 1'b0);
        press("drop", OP_DROP, 8'd0, 8'd3, 3'd1, 1'b0, 1'b0);
        press("addi", OP_ADDI, 8'd255, 8'd2, 3'd1, 1'b1, 1'b0);
        press("sub_under", OP_SUB, 8'd0, 8'd2, 3'd1, 1'b1, 1'b1);
        press("clear3", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        press("fill1", OP_PUSH, 8'd1, 8'd1, 3'd1, 1'b0, 1'b0);
        press("fill2", OP_PUSH, 8'd2, 8'd2, 3'd2, 1'b0, 1'b0);
        press("fill3", OP_PUSH, 8'd3, 8'd3, 3'd3, 1'b0, 1'b0);
        press("fill4", OP_PUSH, 8'd4, 8'd4, 3'd4, 1'b0, 1'b0);
        press("push_over", OP_PUSH, 8'd5, 8'd4, 3'd4, 1'b0, 1'b1);
        press("dup_over", OP_DUP, 8'd0, 8'd4, 3'd4, 1'b0, 1'b1);
        press("clear4", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        press("add_empty", OP_ADD, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        press("clear5", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        press("drop_empty", OP_DROP, 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        press("clear6", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);
        rsv = 4'd14;
        press("reserved14", op_e'(rsv), 8'd0, 8'd0, 3'd0, 1'b0, 1'b1);
        press("push_w_err", OP_PUSH, 8'd9, 8'd9, 3'd1, 1'b0, 1'b1);
        press("clear7", OP_CLEAR, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0);

        bus.Enter = 1'b0;
        @(negedge clock);
        bus.OpIn  = OP_PUSH;
        bus.NumIn = 8'd9;
        bus.Enter = 1'b1;
        repeat (10) @(negedge clock);
        expect_state("hold10", 8'd9, 3'd1, 1'b0, 1'b0);
        check_state();
        press("repress", OP_PUSH, 8'd6, 8'd6, 3'd2, 1'b0, 1'b0);

        @(negedge clock);
        Reset     = 1'b1;
        bus.OpIn  = OP_PUSH;
        bus.NumIn = 8'd77;
        bus.Enter = 1'b1;
        @(negedge clock);
        expect_state("reset_wins", 8'd0, 3'd0, 1'b0, 1'b0);
        check_state();
        Reset = 1'b0;
        repeat (3) @(negedge clock);
        expect_state("held_after_reset", 8'd0, 3'd0, 1'b0, 1'b0);
        check_state();
        press("after_release", OP_PUSH, 8'd8, 8'd8, 3'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
